// File: rtl/lambo_exec_unit_pkg.sv
// rtl/lambo_exec_unit_pkg.sv - shared opcodes, FSM states and compare-mode constants
package lambo_exec_unit_pkg;

    localparam logic [2:0] OPC_CMP    = 3'd0;
    localparam logic [2:0] OPC_BRANCH = 3'd1;
    localparam logic [2:0] OPC_LDR    = 3'd2;
    localparam logic [2:0] OPC_STR    = 3'd3;
    localparam logic [2:0] OPC_XOR    = 3'd4;
    localparam logic [2:0] OPC_ADD    = 3'd5;
    localparam logic [2:0] OPC_SUB    = 3'd6;
    localparam logic [2:0] OPC_LSHIFT = 3'd7;

    typedef enum logic [2:0] {
        OP_CMP    = OPC_CMP,
        OP_BRANCH = OPC_BRANCH,
        OP_LDR    = OPC_LDR,
        OP_STR    = OPC_STR,
        OP_XOR    = OPC_XOR,
        OP_ADD    = OPC_ADD,
        OP_SUB    = OPC_SUB,
        OP_LSHIFT = OPC_LSHIFT
    } op_mne;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } exec_state_t;

    localparam logic CMP_EQ = 1'b0;
    localparam logic CMP_LT = 1'b1;

endpackage

// File: rtl/lambo_exec_unit_if.sv
// rtl/lambo_exec_unit_if.sv - issue/result handshake bundle of the execution unit
interface lambo_exec_unit_if
    import lambo_exec_unit_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    op_mne            op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cmp_lt;
    logic             cmp_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             br_taken;
    logic             cmp_flag;

    modport master (
        output in_valid, op, a, b, cmp_lt, cmp_signed, out_ready,
        input  in_ready, out_valid, result, carry, br_taken, cmp_flag
    );

    modport slave (
        input  in_valid, op, a, b, cmp_lt, cmp_signed, out_ready,
        output in_ready, out_valid, result, carry, br_taken, cmp_flag
    );
endinterface

// File: rtl/lambo_exec_unit_serial_shifter.sv
// rtl/lambo_exec_unit_serial_shifter.sv - one-bit-per-cycle left shifter with down-counter
module lambo_exec_unit_serial_shifter #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic [SHW-1:0]   count_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] shifted_o
);
    logic [WIDTH-1:0] work_q;
    logic [SHW-1:0]   cnt_q;

    // shifted_o is the value after this cycle's shift, so done_o marks the final step
    assign shifted_o = {work_q[WIDTH-2:0], 1'b0};
    assign busy_o    = (cnt_q != '0);
    assign done_o    = (cnt_q == SHW'(1));

    // Working register and remaining-shift counter
    always_ff @(posedge clk) begin
        if (reset) begin
            work_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            work_q <= value_i;
            cnt_q  <= count_i;
        end else if (busy_o) begin
            work_q <= shifted_o;
            cnt_q  <= cnt_q - SHW'(1);
        end
    end
endmodule

// File: rtl/lambo_exec_unit.sv
// rtl/lambo_exec_unit.sv - handshaked execution unit with compare flag, carry and serial shift
module lambo_exec_unit
    import lambo_exec_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    lambo_exec_unit_if.slave   bus
);
    exec_state_t      state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             br_q, br_d;
    logic             flag_q, flag_d;

    logic             in_ready;
    logic             out_valid;
    logic             accept;
    logic [WIDTH:0]   sum;
    logic             lt;
    logic [SHW-1:0]   shamt;
    logic             shift_start;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             sh_busy;
    logic             sh_done;
    logic [WIDTH-1:0] sh_value;

    assign accept      = bus.in_valid & in_ready;
    assign sum         = {1'b0, bus.a} + {1'b0, bus.b};
    assign lt          = bus.cmp_signed ? ($signed(bus.a) < $signed(bus.b)) : (bus.a < bus.b);
    // Shift amounts of WIDTH or more all clear the operand, so saturate at WIDTH
    assign shamt       = (bus.b >= WIDTH'(WIDTH)) ? SHW'(WIDTH) : bus.b[SHW-1:0];
    assign shift_start = accept & (bus.op == OP_LSHIFT) & (shamt != '0);

    lambo_exec_unit_serial_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load_i    (shift_start),
        .value_i   (bus.a),
        .count_i   (shamt),
        .busy_o    (sh_busy),
        .done_o    (sh_done),
        .shifted_o (sh_value)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = shift_start ? SHIFT : DONE;
            SHIFT:   if (sh_done || !sh_busy) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = accept ? (shift_start ? SHIFT : DONE) : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
        out_valid = (state_q == DONE);
    end

    // Single-cycle op mux; LSHIFT passes a through for the zero-count case
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (bus.op)
            OP_XOR:         alu_res = bus.a ^ bus.b;
            OP_ADD:         {alu_carry, alu_res} = sum;
            OP_SUB: begin
                alu_res   = bus.a - bus.b;
                alu_carry = (bus.a < bus.b);
            end
            OP_LDR, OP_STR: alu_res = sum[WIDTH-1:0];
            OP_BRANCH:      alu_res = bus.b;
            OP_LSHIFT:      alu_res = bus.a;
            default:        alu_res = '0;
        endcase
    end

    // Next values of the result registers and the compare flag
    always_comb begin
        result_d = result_q;
        carry_d  = carry_q;
        br_d     = br_q;
        flag_d   = flag_q;
        if (accept) begin
            result_d = alu_res;
            carry_d  = alu_carry;
            br_d     = (bus.op == OP_BRANCH) & flag_q;
            if (bus.op == OP_CMP)
                flag_d = (bus.cmp_lt == CMP_LT) ? lt : (bus.a == bus.b);
        end else if ((state_q == SHIFT) && sh_done) begin
            result_d = sh_value;
        end
    end

    // Result, carry, branch outcome and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            br_q     <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            br_q     <= br_d;
            flag_q   <= flag_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.br_taken  = br_q;
    assign bus.cmp_flag  = flag_q;
endmodule

// File: tb/tb_lambo_exec_unit.sv
// tb/tb_lambo_exec_unit.sv - directed self-checking bench for lambo_exec_unit
module tb_lambo_exec_unit;
    import lambo_exec_unit_pkg::*;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    lambo_exec_unit_if #(.WIDTH(8)) bus ();

    lambo_exec_unit #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input op_mne op, input logic [7:0] a, input logic [7:0] b,
                         input logic lt, input logic sgn);
        bus.in_valid   = 1'b1;
        bus.op         = op;
        bus.a          = a;
        bus.b          = b;
        bus.cmp_lt     = lt;
        bus.cmp_signed = sgn;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.op         = OP_CMP;
        bus.a          = 8'h00;
        bus.b          = 8'h00;
        bus.cmp_lt     = 1'b0;
        bus.cmp_signed = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result",    32'(bus.result),    32'd0);
        check("rst_carry",     32'(bus.carry),     32'd0);
        check("rst_br_taken",  32'(bus.br_taken),  32'd0);
        check("rst_cmp_flag",  32'(bus.cmp_flag),  32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);

        issue(OP_ADD, 8'hF0, 8'h20, 1'b0, 1'b0);
        tick();
        check("add_valid",  32'(bus.out_valid), 32'd1);
        check("add_result", 32'(bus.result),    32'h10);
        check("add_carry",  32'(bus.carry),     32'd1);

        issue(OP_SUB, 8'h03, 8'h05, 1'b0, 1'b0);
        check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("sub_result", 32'(bus.result), 32'hFE);
        check("sub_carry",  32'(bus.carry),  32'd1);

        issue(OP_XOR, 8'hAA, 8'h0F, 1'b0, 1'b0);
        tick();
        check("xor_result", 32'(bus.result),    32'hA5);
        check("xor_carry",  32'(bus.carry),     32'd0);
        check("xor_valid",  32'(bus.out_valid), 32'd1);

        issue(OP_CMP, 8'hFF, 8'h01, 1'b1, 1'b1);
        tick();
        check("cmps_flag",   32'(bus.cmp_flag), 32'd1);
        check("cmps_result", 32'(bus.result),   32'd0);

        issue(OP_BRANCH, 8'h00, 8'h40, 1'b0, 1'b0);
        tick();
        check("br1_result", 32'(bus.result),   32'h40);
        check("br1_taken",  32'(bus.br_taken), 32'd1);

        issue(OP_CMP, 8'hFF, 8'h01, 1'b1, 1'b0);
        tick();
        check("cmpu_flag",     32'(bus.cmp_flag), 32'd0);
        check("cmpu_br_clear", 32'(bus.br_taken), 32'd0);

        issue(OP_BRANCH, 8'h00, 8'h40, 1'b0, 1'b0);
        tick();
        check("br2_result", 32'(bus.result),   32'h40);
        check("br2_taken",  32'(bus.br_taken), 32'd0);

        issue(OP_LDR, 8'h30, 8'h05, 1'b0, 1'b0);
        tick();
        check("ldr_result", 32'(bus.result), 32'h35);
        check("ldr_carry",  32'(bus.carry),  32'd0);

        issue(OP_LSHIFT, 8'h03, 8'h03, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("sh3_busy_valid_%0d", i), 32'(bus.out_valid), 32'd0);
            check($sformatf("sh3_busy_ready_%0d", i), 32'(bus.in_ready),  32'd0);
            tick();
        end
        check("sh3_valid",  32'(bus.out_valid), 32'd1);
        check("sh3_result", 32'(bus.result),    32'h18);

        issue(OP_LSHIFT, 8'h03, 8'h09, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("sh9_busy_valid_%0d", i), 32'(bus.out_valid), 32'd0);
            tick();
        end
        check("sh9_valid",  32'(bus.out_valid), 32'd1);
        check("sh9_result", 32'(bus.result),    32'h00);

        issue(OP_LSHIFT, 8'h03, 8'h00, 1'b0, 1'b0);
        tick();
        check("sh0_valid",  32'(bus.out_valid), 32'd1);
        check("sh0_result", 32'(bus.result),    32'h03);

        issue(OP_ADD, 8'h10, 8'h22, 1'b0, 1'b0);
        tick();
        check("bp_add_result", 32'(bus.result), 32'h32);
        bus.out_ready = 1'b0;
        issue(OP_XOR, 8'h55, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_in_ready_%0d", i), 32'(bus.in_ready),  32'd0);
            check($sformatf("bp_valid_%0d", i),    32'(bus.out_valid), 32'd1);
            check($sformatf("bp_result_%0d", i),   32'(bus.result),    32'h32);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_xor_result", 32'(bus.result),    32'hAA);
        check("bp_xor_valid",  32'(bus.out_valid), 32'd1);
        tick();
        check("drain_valid", 32'(bus.out_valid), 32'd0);

        issue(OP_CMP, 8'h05, 8'h05, 1'b0, 1'b0);
        tick();
        check("cmpeq_flag", 32'(bus.cmp_flag), 32'd1);
        issue(OP_LSHIFT, 8'h01, 8'h05, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("midsh_valid", 32'(bus.out_valid), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst2_result",    32'(bus.result),    32'd0);
        check("rst2_carry",     32'(bus.carry),     32'd0);
        check("rst2_br_taken",  32'(bus.br_taken),  32'd0);
        check("rst2_cmp_flag",  32'(bus.cmp_flag),  32'd0);
        check("rst2_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst2_state",     32'(dut.state_q),   32'(IDLE));
        repeat (6) tick();
        check("rst2_stays_idle", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
